// File: rtl/cpu_pkg.sv
// Shared constants, IR field positions and fetch FSM encoding
// for the 16-bit register CPU front end.
package cpu_pkg;

  localparam logic [15:0] NOP_WORD = 16'h0000;
  localparam logic [15:0] RESET_PC = 16'h0000;

  localparam int ALUF_HI = 15;
  localparam int ALUF_LO = 12;
  localparam int DST_HI  = 11;
  localparam int DST_LO  = 8;
  localparam int SRC_HI  = 7;
  localparam int SRC_LO  = 4;
  localparam int M_BIT   = 3;
  localparam int CC_HI   = 2;
  localparam int CC_LO   = 0;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_STALL    = 2'd2
  } fetch_st_t;

endpackage

// File: rtl/ir_pipe_pc_reg.sv
// Loadable 16-bit program counter with sync reset and wrapping increment.
// Ports: clk, reset, load/load_val, inc -> q. Priority reset > load > inc.
module pc_reg #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= RESET_VAL;
    else if (load)
      q <= load_val;
    else if (inc)
      q <= q + 16'd1;
  end

endmodule

// File: rtl/ir_pipe.sv
// Instruction fetch and IR pipeline: owns PC, fetch request, ir0q/ir1q.
// In: clk, reset, mem_data/mem_rdy, bus_busy, clrIr0, dojump/jump_target,
// hold. Out: ir0q, ir1q, pc_q, fetch_addr, fetch_req, pipe_adv.
module ir_pipe #(
  parameter logic [15:0] NOP_WORD = cpu_pkg::NOP_WORD,
  parameter logic [15:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_data,
  input  logic        mem_rdy,
  input  logic        bus_busy,
  input  logic        clrIr0,
  input  logic        dojump,
  input  logic [15:0] jump_target,
  input  logic        hold,
  output logic [15:0] ir0q,
  output logic [15:0] ir1q,
  output logic [15:0] pc_q,
  output logic [15:0] fetch_addr,
  output logic        fetch_req,
  output logic        pipe_adv
);
  import cpu_pkg::*;

  fetch_st_t st_q, st_d;
  logic      fetching;

  assign fetching   = (st_q == ST_FETCH);
  assign fetch_req  = fetching & ~bus_busy & ~hold & ~reset;
  assign pipe_adv   = fetching & ~hold & mem_rdy & ~dojump;
  assign fetch_addr = pc_q;

  // A stolen bus cycle still shifts the pipe but fetches nothing.
  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (dojump),
    .load_val(jump_target),
    .inc     (pipe_adv & ~bus_busy),
    .q       (pc_q)
  );

  always_ff @(posedge clk) begin
    if (reset)
      st_q <= ST_REDIRECT;
    else
      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (dojump) begin
      st_d = ST_REDIRECT;
    end else begin
      unique case (st_q)
        ST_FETCH:    if (hold) st_d = ST_STALL;
        ST_REDIRECT: st_d = ST_FETCH;
        ST_STALL:    if (!hold) st_d = ST_FETCH;
        default:     st_d = ST_REDIRECT;
      endcase
    end
  end

  // clrIr0 marks the fetched word as immediate data, not an instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir0q <= NOP_WORD;
      ir1q <= NOP_WORD;
    end else if (dojump) begin
      ir0q <= NOP_WORD;
      ir1q <= NOP_WORD;
    end else if (pipe_adv) begin
      ir1q <= ir0q;
      ir0q <= (bus_busy | clrIr0) ? NOP_WORD : mem_data;
    end
  end

endmodule

// File: tb/tb_ir_pipe.sv
// Bench for ir_pipe: directed vector table, then random stimulus
// checked against a cycle-level reference model.
module tb_ir_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_data;
  logic        mem_rdy;
  logic        bus_busy;
  logic        clrIr0;
  logic        dojump;
  logic [15:0] jump_target;
  logic        hold;
  logic [15:0] ir0q, ir1q, pc_q, fetch_addr;
  logic        fetch_req, pipe_adv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ir_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .mem_data   (mem_data),
    .mem_rdy    (mem_rdy),
    .bus_busy   (bus_busy),
    .clrIr0     (clrIr0),
    .dojump     (dojump),
    .jump_target(jump_target),
    .hold       (hold),
    .ir0q       (ir0q),
    .ir1q       (ir1q),
    .pc_q       (pc_q),
    .fetch_addr (fetch_addr),
    .fetch_req  (fetch_req),
    .pipe_adv   (pipe_adv)
  );

  typedef struct {
    logic        rst, rdy, bb, clr, dj, hld;
    logic [15:0] data, jt;
    logic        cc;
    logic        e_req, e_adv;
    logic [15:0] e_addr, e_pc, e_ir0, e_ir1;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(
    input logic rst, rdy, bb, clr, dj, hld,
    input logic [15:0] data, jt,
    input logic cc, e_req, e_adv,
    input logic [15:0] e_addr, e_pc, e_ir0, e_ir1);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.bb = bb;
    v.clr = clr; v.dj = dj; v.hld = hld;
    v.data = data; v.jt = jt; v.cc = cc;
    v.e_req = e_req; v.e_adv = e_adv;
    v.e_addr = e_addr; v.e_pc = e_pc;
    v.e_ir0 = e_ir0; v.e_ir1 = e_ir1;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, rdy, bb, clr, dj, hld,
                       input logic [15:0] data, jt);
    reset = rst; mem_rdy = rdy; bus_busy = bb;
    clrIr0 = clr; dojump = dj; hold = hld;
    mem_data = data; jump_target = jt;
  endtask

  // reference model state
  logic [15:0] m_pc, m_ir0, m_ir1;
  bit          m_redir, m_stall;

  initial begin
    // rst rdy bb clr dj hld data jt | cc req adv addr pc ir0 ir1
    tbl[0]  = mk(1,1,0,0,0,0,16'h9999,0, 0,0,0,0,     0,     0,0);
    tbl[1]  = mk(0,1,0,0,0,0,16'h1340,0, 1,0,0,0,     0,     0,0);
    tbl[2]  = mk(0,1,0,0,0,0,16'h1340,0, 1,1,1,0,     1,16'h1340,0);
    tbl[3]  = mk(0,1,0,0,0,0,16'h2350,0, 1,1,1,1,     2,16'h2350,
                 16'h1340);
    tbl[4]  = mk(0,1,0,0,0,0,16'h3360,0, 1,1,1,2,     3,16'h3360,
                 16'h2350);
    tbl[5]  = mk(0,1,0,1,0,0,16'h00AB,0, 1,1,1,3,     4,0,16'h3360);
    tbl[6]  = mk(0,1,0,1,1,0,16'h5555,16'h0040,
                 1,1,0,4,16'h0040,0,0);
    tbl[7]  = mk(0,1,1,0,0,0,16'h7777,0, 1,0,0,16'h0040,16'h0040,0,0);
    tbl[8]  = mk(0,1,0,0,0,0,16'h1111,0, 1,1,1,16'h0040,16'h0041,
                 16'h1111,0);
    tbl[9]  = mk(0,1,1,0,0,0,16'h2222,0, 1,0,1,16'h0041,16'h0041,
                 0,16'h1111);
    tbl[10] = mk(0,1,0,0,0,1,16'h3333,0, 1,0,0,16'h0041,16'h0041,
                 0,16'h1111);
    tbl[11] = mk(0,1,0,0,0,1,16'h3333,0, 1,0,0,16'h0041,16'h0041,
                 0,16'h1111);
    tbl[12] = mk(0,1,0,0,0,0,16'h3333,0, 1,0,0,16'h0041,16'h0041,
                 0,16'h1111);
    tbl[13] = mk(0,1,0,0,1,1,16'h3333,16'hFFFF,
                 1,0,0,16'h0041,16'hFFFF,0,0);
    tbl[14] = mk(0,0,0,0,0,0,16'h4444,0, 1,0,0,16'hFFFF,16'hFFFF,0,0);
    tbl[15] = mk(0,0,0,0,0,0,16'h4444,0, 1,1,0,16'hFFFF,16'hFFFF,0,0);
    tbl[16] = mk(0,0,0,0,0,0,16'h4444,0, 1,1,0,16'hFFFF,16'hFFFF,0,0);
    tbl[17] = mk(0,0,0,0,0,0,16'h4444,0, 1,1,0,16'hFFFF,16'hFFFF,0,0);
    tbl[18] = mk(0,1,0,0,0,0,16'h4444,0, 1,1,1,16'hFFFF,0,16'h4444,0);
    tbl[19] = mk(0,1,0,0,0,0,16'h5555,0, 1,1,1,0,1,16'h5555,16'h4444);
    tbl[20] = mk(1,1,0,0,0,0,16'h6666,0, 1,0,1,1,0,0,0);
    tbl[21] = mk(0,1,0,0,0,0,16'h6666,0, 1,0,0,0,0,0,0);

    drive(1,0,0,0,0,0,0,0);
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].bb, tbl[i].clr,
            tbl[i].dj, tbl[i].hld, tbl[i].data, tbl[i].jt);
      #1;
      if (tbl[i].cc) begin
        chk($sformatf("v%0d fetch_req", i),
            {15'd0, fetch_req}, {15'd0, tbl[i].e_req});
        chk($sformatf("v%0d pipe_adv", i),
            {15'd0, pipe_adv}, {15'd0, tbl[i].e_adv});
        chk($sformatf("v%0d fetch_addr", i),
            fetch_addr, tbl[i].e_addr);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc_q", i), pc_q, tbl[i].e_pc);
      chk($sformatf("v%0d ir0q", i), ir0q, tbl[i].e_ir0);
      chk($sformatf("v%0d ir1q", i), ir1q, tbl[i].e_ir1);
      @(negedge clk);
    end

    // After the last vector the pipe is fetching from pc 0.
    m_pc = 0; m_ir0 = 0; m_ir1 = 0;
    m_redir = 0; m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      logic rst, rdy, bb, clr, dj, hld, act, e_req, e_adv;
      logic [15:0] data, jt;
      rst  = ($urandom_range(63) == 0);
      rdy  = $urandom_range(1);
      bb   = ($urandom_range(3) == 0);
      clr  = ($urandom_range(3) == 0);
      dj   = ($urandom_range(15) == 0);
      hld  = ($urandom_range(7) == 0);
      data = 16'($urandom);
      jt   = (c % 97 == 0) ? 16'hFFFE : 16'($urandom);
      drive(rst, rdy, bb, clr, dj, hld, data, jt);
      act   = !m_redir && !m_stall;
      e_req = act && !bb && !hld && !rst;
      e_adv = act && !hld && rdy && !dj;
      #1;
      chk("rnd fetch_req", {15'd0, fetch_req}, {15'd0, e_req});
      chk("rnd pipe_adv", {15'd0, pipe_adv}, {15'd0, e_adv});
      chk("rnd fetch_addr", fetch_addr, m_pc);
      if (rst) begin
        m_pc = 0; m_ir0 = 0; m_ir1 = 0;
      end else if (dj) begin
        m_pc = jt; m_ir0 = 0; m_ir1 = 0;
      end else if (e_adv) begin
        m_ir1 = m_ir0;
        m_ir0 = (bb || clr) ? 16'h0000 : data;
        if (!bb) m_pc = m_pc + 16'd1;
      end
      m_stall = !rst && !dj && hld && !m_redir;
      m_redir = rst || dj;
      @(posedge clk);
      #1;
      chk("rnd pc_q", pc_q, m_pc);
      chk("rnd ir0q", ir0q, m_ir0);
      chk("rnd ir1q", ir1q, m_ir1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
